systolic_pe_ws: RTL and testbench
=================================

// Module: systolic_pe_ws
// PURPOSE
//  Parametrised weight-stationary processing element for the systolic array; next generation of the array PE.
//  Signed integer MAC with a double-buffered weight: the next weight loads into a shadow register while the current one computes.
//  Carries valid-qualified activation (west->east), partial-sum (north->south) and weight-chain (north->south) paths.
//  Tiled NxN by the array top; selectable 1- or 2-stage MAC pipeline.
// PARAMETERS
//  A_W    8   activation width, signed
//  W_W    8   weight width, signed
//  ACC_W  24  partial-sum width, signed; must be >= A_W+W_W
//  PIPE   1   MAC latency in cycles; legal values 1 or 2
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      reset, asynchronous, active-high
//  i_w_vld     in   1      weight-chain shift strobe
//  i_w         in   W_W    weight from north neighbour
//  o_w_vld     out  1      weight-chain strobe to south, registered
//  o_w         out  W_W    weight to south (previous shadow value)
//  i_swap      in   1      shadow->active swap pulse from north
//  o_swap      out  1      swap pulse to south, registered
//  i_act_vld   in   1      activation valid
//  i_act       in   A_W    activation from west
//  o_act_vld   out  1      activation valid to east
//  o_act       out  A_W    activation to east
//  i_psum_vld  in   1      partial-sum valid from north
//  i_psum      in   ACC_W  partial sum from north
//  o_psum_vld  out  1      partial-sum valid to south
//  o_psum      out  ACC_W  partial sum to south
// BEHAVIOUR
//  - Reset: every register clears to 0 asynchronously; all outputs are 0 while rst=1 and in the cycle after release.
//  - Reset mid-operation discards in-flight sums and both weights; no recovery state is kept.
//  - Weight chain: i_w_vld=1 -> shadow<=i_w, o_w<=old shadow, o_w_vld<=1.
//  - With i_w_vld=0: o_w_vld<=0, shadow and o_w hold.
//  - After N strobes into an N-deep column, the top PE holds the last word and the bottom PE holds the first.
//  - Swap: i_swap=1 -> active<=shadow; o_swap<=i_swap. Swap ripples down one row per cycle.
//  - Swap with i_w_vld in the same cycle: active takes the OLD shadow, and shadow takes i_w.
//  - Activation path: o_act<=i_act, o_act_vld<=i_act_vld. Latency 1, independent of PIPE.
//  - MAC, i_act_vld=1: result = (i_psum_vld ? i_psum : 0) + sext(i_act*active); o_psum_vld=1.
//  - Bypass, i_act_vld=0: result = i_psum; o_psum_vld = i_psum_vld.
//  - Result latency is PIPE cycles from the i_act/i_psum cycle.
//    PIPE=2: stage 1 registers the product plus the delayed psum and valid; stage 2 registers the sum.
//  - i_act and i_psum for one MAC must arrive in the same cycle; the array top provides the row skew.
//  - The multiply is full-precision A_W+W_W, sign-extended to ACC_W. The add is ACC_W-bit two's complement.
//  - A swap while MACs are in flight affects only products started after the swap edge.
//  - o_psum holds its last value when no valid is flowing; consumers qualify it with o_psum_vld.
// CONFIGURATION
//  PE_SAT_EN defined:
//    - Signed-overflow add clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)).
//    - Bypass results are never altered.
//  PE_SAT_EN undefined:
//    - Two's-complement wrap-around; no clamp logic is built.
//  The macro does not change ports or latency.
// TESTING
//  T1 PIPE=1: load w=3, swap; act=5 vld, psum=100 vld -> next cycle o_psum=115, o_psum_vld=1.
//  T2 PIPE=2: act=-4, w=7, psum_vld=0 -> o_psum=-28 two cycles later; o_act=-4 after one cycle.
//  T3 weight strobe and swap in the same cycle: shadow=9, i_w=2 -> active=9, shadow=2; o_w=9, o_w_vld=1.
//  T4 i_act_vld=0, i_psum=1234, vld=1 -> o_psum=1234, vld=1 after PIPE cycles; no MAC contribution.
//  T5 psum=8388600, act=127, w=127:
//     - without PE_SAT_EN -> o_psum=-8372487
//     - with PE_SAT_EN -> o_psum=8388607
//  T6 assert rst mid-stream with 2 MACs in flight -> all outputs 0 immediately; act=5 after release -> o_psum=0 (weight cleared).

Source files
------------

// File: rtl/systolic_pe_ws.sv
// systolic_pe_ws: weight-stationary signed MAC PE with double-buffered weight and 1/2-stage MAC pipeline.
// Define PE_SAT_EN to clamp MAC overflow to the ACC_W signed range instead of wrapping.
module systolic_pe_ws #(
   parameter int A_W   = 8,
   parameter int W_W   = 8,
   parameter int ACC_W = 24,
   parameter int PIPE  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_w_vld,
   input  logic signed [W_W-1:0]   i_w,
   output logic                    o_w_vld,
   output logic signed [W_W-1:0]   o_w,
   input  logic                    i_swap,
   output logic                    o_swap,
   input  logic                    i_act_vld,
   input  logic signed [A_W-1:0]   i_act,
   output logic                    o_act_vld,
   output logic signed [A_W-1:0]   o_act,
   input  logic                    i_psum_vld,
   input  logic signed [ACC_W-1:0] i_psum,
   output logic                    o_psum_vld,
   output logic signed [ACC_W-1:0] o_psum
);
   logic signed [W_W-1:0]       shadow, active;
   logic signed [A_W+W_W-1:0]   full;
   logic signed [ACC_W-1:0]     prod, addend;
   logic                        vld;

   function automatic logic signed [ACC_W-1:0] add(input logic signed [ACC_W-1:0] a,
                                                   input logic signed [ACC_W-1:0] b);
      logic signed [ACC_W-1:0] s;
      s = a + b;
`ifdef PE_SAT_EN
      // a bypass adds zero, so it can never trip the clamp
      if (a[ACC_W-1] == b[ACC_W-1] && s[ACC_W-1] != a[ACC_W-1])
         s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
      return s;
   endfunction

   assign full = (A_W+W_W)'(i_act) * (A_W+W_W)'(active);

   always_comb begin
      prod   = i_act_vld ? ACC_W'(full) : '0;
      addend = (i_act_vld && !i_psum_vld) ? '0 : i_psum;
      vld    = i_act_vld | i_psum_vld;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shadow    <= '0;
         active    <= '0;
         o_w       <= '0;
         o_w_vld   <= 1'b0;
         o_swap    <= 1'b0;
         o_act     <= '0;
         o_act_vld <= 1'b0;
      end else begin
         o_w_vld   <= i_w_vld;
         o_swap    <= i_swap;
         o_act     <= i_act;
         o_act_vld <= i_act_vld;
         if (i_w_vld) begin
            shadow <= i_w;
            o_w    <= shadow;
         end
         if (i_swap) active <= shadow;
      end

   generate
      if (PIPE == 2) begin : g_pipe2
         logic signed [ACC_W-1:0] p_r, a_r;
         logic                    v_r;
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               p_r        <= '0;
               a_r        <= '0;
               v_r        <= 1'b0;
               o_psum     <= '0;
               o_psum_vld <= 1'b0;
            end else begin
               v_r        <= vld;
               o_psum_vld <= v_r;
               if (vld) begin
                  p_r <= prod;
                  a_r <= addend;
               end
               if (v_r) o_psum <= add(a_r, p_r);
            end
      end else begin : g_pipe1
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               o_psum     <= '0;
               o_psum_vld <= 1'b0;
            end else begin
               o_psum_vld <= vld;
               if (vld) o_psum <= add(addend, prod);
            end
      end
   endgenerate
endmodule

// File: tb/tb_systolic_pe_ws.sv
// tb_systolic_pe_ws: checks PIPE=1 and PIPE=2 instances side by side against an arithmetic reference model.
module tb_systolic_pe_ws;
   localparam int A_W = 8, W_W = 8, ACC_W = 24;

   logic clk = 0, rst = 0;
   logic i_w_vld = 0, i_swap = 0, i_act_vld = 0, i_psum_vld = 0;
   logic signed [W_W-1:0]   i_w = '0;
   logic signed [A_W-1:0]   i_act = '0;
   logic signed [ACC_W-1:0] i_psum = '0;

   logic o_w_vld1, o_swap1, o_act_vld1, o_psum_vld1;
   logic o_w_vld2, o_swap2, o_act_vld2, o_psum_vld2;
   logic signed [W_W-1:0]   o_w1, o_w2;
   logic signed [A_W-1:0]   o_act1, o_act2;
   logic signed [ACC_W-1:0] o_psum1, o_psum2;

   int checks = 0, errors = 0;

   int     m_shadow, m_active, m_ow, m_act;
   logic   m_owv, m_swap, m_actv;
   longint m1, m2, d_r;
   logic   m1v, m2v, d_v;

   always #5 clk = ~clk;

   systolic_pe_ws #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .PIPE(1)) u1 (
      .clk(clk), .rst(rst), .i_w_vld(i_w_vld), .i_w(i_w), .o_w_vld(o_w_vld1), .o_w(o_w1),
      .i_swap(i_swap), .o_swap(o_swap1), .i_act_vld(i_act_vld), .i_act(i_act),
      .o_act_vld(o_act_vld1), .o_act(o_act1), .i_psum_vld(i_psum_vld), .i_psum(i_psum),
      .o_psum_vld(o_psum_vld1), .o_psum(o_psum1));

   systolic_pe_ws #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .PIPE(2)) u2 (
      .clk(clk), .rst(rst), .i_w_vld(i_w_vld), .i_w(i_w), .o_w_vld(o_w_vld2), .o_w(o_w2),
      .i_swap(i_swap), .o_swap(o_swap2), .i_act_vld(i_act_vld), .i_act(i_act),
      .o_act_vld(o_act_vld2), .o_act(o_act2), .i_psum_vld(i_psum_vld), .i_psum(i_psum),
      .o_psum_vld(o_psum_vld2), .o_psum(o_psum2));

   // wrap or clamp an exact integer result into the ACC_W signed range
   function automatic longint fit(input longint r, input logic mac);
      longint hi = (longint'(1) << (ACC_W-1)) - 1;
      longint lo = -(longint'(1) << (ACC_W-1));
`ifdef PE_SAT_EN
      if (mac) return r > hi ? hi : (r < lo ? lo : r);
`endif
      r = r & ((longint'(1) << ACC_W) - 1);
      return r > hi ? r - (longint'(1) << ACC_W) : r;
   endfunction

   task automatic model_clear;
      m_shadow = 0; m_active = 0; m_ow = 0; m_act = 0;
      m_owv = 0; m_swap = 0; m_actv = 0;
      m1 = 0; m2 = 0; d_r = 0; m1v = 0; m2v = 0; d_v = 0;
   endtask

   task automatic step(input logic wv, input int w, input logic sw, input logic av,
                       input int a, input logic pv, input longint p);
      longint r;
      logic   rv;
      i_w_vld = wv; i_w = W_W'(w); i_swap = sw;
      i_act_vld = av; i_act = A_W'(a); i_psum_vld = pv; i_psum = ACC_W'(p);
      rv = av | pv;
      r  = av ? fit((pv ? p : 0) + longint'(a) * m_active, 1'b1) : p;
      @(posedge clk); #1;
      if (sw) m_active = m_shadow;
      if (wv) begin m_ow = m_shadow; m_shadow = w; end
      m_owv = wv; m_swap = sw; m_act = a; m_actv = av;
      m2v = d_v;
      if (d_v) m2 = d_r;
      d_v = rv; d_r = r;
      m1v = rv;
      if (rv) m1 = r;
   endtask

   task automatic test_reset;
      #2 rst = 1; #2;
      checks++;
      if ({o_w_vld1, o_w1, o_swap1, o_act_vld1, o_act1, o_psum_vld1, o_psum1,
           o_w_vld2, o_w2, o_swap2, o_act_vld2, o_act2, o_psum_vld2, o_psum2} !== '0) begin
         errors++; $display("FAIL reset_async: outputs nonzero u1 psum=%0d u2 psum=%0d", o_psum1, o_psum2);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 0; model_clear(); #1;
      checks++;
      if ({o_w_vld1, o_w1, o_swap1, o_act_vld1, o_act1, o_psum_vld1, o_psum1,
           o_w_vld2, o_w2, o_swap2, o_act_vld2, o_act2, o_psum_vld2, o_psum2} !== '0) begin
         errors++; $display("FAIL reset_release: outputs nonzero after release");
      end
   endtask

   task automatic test_mac;
      step(1, 3, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 5, 1, 100);
      checks++;
      if (o_psum1 !== 24'sd115 || o_psum_vld1 !== 1'b1) begin
         errors++; $display("FAIL t1_pipe1: got %0d/%b want 115/1", o_psum1, o_psum_vld1);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (o_psum2 !== 24'sd115 || o_psum_vld2 !== 1'b1) begin
         errors++; $display("FAIL t1_pipe2: got %0d/%b want 115/1", o_psum2, o_psum_vld2);
      end
      checks++;
      if (o_psum1 !== 24'sd115 || o_psum_vld1 !== 1'b0) begin
         errors++; $display("FAIL hold_pipe1: got %0d/%b want 115/0", o_psum1, o_psum_vld1);
      end
   endtask

   task automatic test_pipe2;
      step(1, 7, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, -4, 0, 0);
      checks++;
      if (o_act1 !== -8'sd4 || o_act2 !== -8'sd4 || o_act_vld2 !== 1'b1 || o_psum_vld2 !== 1'b0) begin
         errors++; $display("FAIL t2_act: got act %0d/%0d vld %b psum_vld2 %b want -4/-4 1 0",
                            o_act1, o_act2, o_act_vld2, o_psum_vld2);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (o_psum2 !== -24'sd28 || o_psum_vld2 !== 1'b1) begin
         errors++; $display("FAIL t2_pipe2: got %0d/%b want -28/1", o_psum2, o_psum_vld2);
      end
   endtask

   task automatic test_swap_strobe;
      step(1, 9, 0, 0, 0, 0, 0);
      step(1, 2, 1, 0, 0, 0, 0);
      checks++;
      if (o_w1 !== 8'sd9 || o_w_vld1 !== 1'b1 || o_swap1 !== 1'b1) begin
         errors++; $display("FAIL t3_chain: got o_w=%0d vld=%b swap=%b want 9 1 1", o_w1, o_w_vld1, o_swap1);
      end
      step(0, 0, 0, 1, 1, 0, 0);
      checks++;
      if (o_psum1 !== 24'sd9 || o_swap1 !== 1'b0 || o_w_vld1 !== 1'b0 || o_w1 !== 8'sd9) begin
         errors++; $display("FAIL t3_active: got psum=%0d swap=%b wvld=%b o_w=%0d want 9 0 0 9",
                            o_psum1, o_swap1, o_w_vld1, o_w1);
      end
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      checks++;
      if (o_psum1 !== 24'sd2) begin
         errors++; $display("FAIL t3_shadow: got %0d want 2", o_psum1);
      end
   endtask

   task automatic test_bypass;
      step(0, 0, 0, 0, 0, 1, 1234);
      checks++;
      if (o_psum1 !== 24'sd1234 || o_psum_vld1 !== 1'b1) begin
         errors++; $display("FAIL t4_pipe1: got %0d/%b want 1234/1", o_psum1, o_psum_vld1);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (o_psum2 !== 24'sd1234 || o_psum_vld2 !== 1'b1) begin
         errors++; $display("FAIL t4_pipe2: got %0d/%b want 1234/1", o_psum2, o_psum_vld2);
      end
   endtask

   task automatic test_overflow;
      logic signed [ACC_W-1:0] exp_v;
`ifdef PE_SAT_EN
      exp_v = 24'sd8388607;
`else
      exp_v = -24'sd8372487;
`endif
      step(1, 127, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 127, 1, 8388600);
      checks++;
      if (o_psum1 !== exp_v) begin
         errors++; $display("FAIL t5_pipe1: got %0d want %0d", o_psum1, exp_v);
      end
      step(0, 0, 0, 1, -128, 1, -8388600);
      checks++;
      if (o_psum2 !== exp_v) begin
         errors++; $display("FAIL t5_pipe2: got %0d want %0d", o_psum2, exp_v);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (o_psum2 !== ACC_W'(m2) || o_psum1 !== ACC_W'(m1)) begin
         errors++; $display("FAIL t5_neg: got %0d/%0d want %0d/%0d", o_psum1, o_psum2, m1, m2);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, int'($urandom_range(0, 255)) - 128,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, int'($urandom_range(0, 255)) - 128,
              $urandom_range(0, 1) == 1, longint'(int'($urandom) >>> 8));
         checks++;
         if ({o_w_vld1, o_w1, o_swap1, o_act_vld1, o_act1} !== {m_owv, W_W'(m_ow), m_swap, m_actv, A_W'(m_act)} ||
             {o_w_vld2, o_w2, o_swap2, o_act_vld2, o_act2} !== {m_owv, W_W'(m_ow), m_swap, m_actv, A_W'(m_act)}) begin
            errors++; $display("FAIL rand_paths[%0d]: got w=%0d/%0d act=%0d/%0d want w=%0d act=%0d",
                               n, o_w1, o_w2, o_act1, o_act2, m_ow, m_act);
         end
         checks++;
         if (o_psum1 !== ACC_W'(m1) || o_psum_vld1 !== m1v) begin
            errors++; $display("FAIL rand_pipe1[%0d]: got %0d/%b want %0d/%b", n, o_psum1, o_psum_vld1, m1, m1v);
         end
         checks++;
         if (o_psum2 !== ACC_W'(m2) || o_psum_vld2 !== m2v) begin
            errors++; $display("FAIL rand_pipe2[%0d]: got %0d/%b want %0d/%b", n, o_psum2, o_psum_vld2, m2, m2v);
         end
      end
   endtask

   task automatic test_reset_mid;
      step(1, 3, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 10, 1, 50);
      step(0, 0, 0, 1, 11, 1, 60);
      #2 rst = 1; #1;
      checks++;
      if ({o_w_vld1, o_w1, o_swap1, o_act_vld1, o_act1, o_psum_vld1, o_psum1,
           o_w_vld2, o_w2, o_swap2, o_act_vld2, o_act2, o_psum_vld2, o_psum2} !== '0) begin
         errors++; $display("FAIL t6_async: outputs nonzero u1 psum=%0d u2 psum=%0d", o_psum1, o_psum2);
      end
      model_clear();
      @(negedge clk); rst = 0;
      step(0, 0, 0, 1, 5, 0, 0);
      checks++;
      if (o_psum1 !== 24'sd0 || o_psum_vld1 !== 1'b1 || o_psum_vld2 !== 1'b0) begin
         errors++; $display("FAIL t6_pipe1: got %0d/%b vld2 %b want 0/1 0", o_psum1, o_psum_vld1, o_psum_vld2);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (o_psum2 !== 24'sd0 || o_psum_vld2 !== 1'b1) begin
         errors++; $display("FAIL t6_pipe2: got %0d/%b want 0/1", o_psum2, o_psum_vld2);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_mac();
      test_pipe2();
      test_swap_strobe();
      test_bypass();
      test_overflow();
      test_random();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
